// File: rtl/mem2nfifo_flow_writer.sv
// Round-robin burst writer from FLOWS input streams into mem2nfifo; write path is zero-latency, commits one cycle after burst end.
// Backpressure: FULL of the granted flow blocks the transfer, drops IN_DST_RDY and ends the burst.
module mem2nfifo_flow_writer #(
   parameter  int DATA_WIDTH = 64,
   parameter  int FLOWS      = 8,
   parameter  int BLOCK_SIZE = 512,
   parameter  int MAX_BURST  = 16,
   localparam int AW         = $clog2(FLOWS),
   localparam int LW         = $clog2(BLOCK_SIZE) + 1,
   localparam int CW         = $clog2(MAX_BURST) + 1
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic [FLOWS*DATA_WIDTH-1:0] in_data_i,
   input  logic [FLOWS-1:0]            in_src_rdy_i,
   input  logic [FLOWS-1:0]            in_eop_i,
   output logic [FLOWS-1:0]            in_dst_rdy_o,
   output logic [DATA_WIDTH-1:0]       data_out_o,
   output logic [AW-1:0]               block_addr_o,
   output logic                        write_o,
   output logic [FLOWS*LW-1:0]         new_len_o,
   output logic [FLOWS-1:0]            new_len_dv_o,
   input  logic [FLOWS-1:0]            full_i
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [AW-1:0]   grant_q, grant_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [LW-1:0]   len_q [FLOWS];
   logic [LW-1:0]   len_d [FLOWS];
   logic [FLOWS-1:0] dv_q, dv_d;

   logic [DATA_WIDTH-1:0] in_word [FLOWS];
   logic [FLOWS-1:0]      eligible;
   logic [AW-1:0]         idx;
   logic [AW-1:0]         pick;
   logic                  found;
   logic                  xfer;
   logic                  burst_end;
   logic [CW-1:0]         cnt_inc;
   logic [CW-1:0]         final_cnt;

   for (genvar f = 0; f < FLOWS; f++) begin : g_flow
      assign in_word[f]                = in_data_i[f*DATA_WIDTH +: DATA_WIDTH];
      assign new_len_o[f*LW +: LW]     = len_q[f];
   end

   assign eligible     = in_src_rdy_i & ~full_i;
   assign new_len_dv_o = dv_q;

   // Rotating priority search starting at the pointer; AW-bit addition wraps naturally.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int i = 0; i < FLOWS; i++) begin
         idx = ptr_q + AW'(i);
         if (!found && eligible[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      grant_d      = grant_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      dv_d         = '0;
      in_dst_rdy_o = '0;
      write_o      = 1'b0;
      data_out_o   = '0;
      block_addr_o = '0;
      xfer         = 1'b0;
      burst_end    = 1'b0;
      cnt_inc      = cnt_q + CW'(1);
      final_cnt    = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d = pick;
               cnt_d   = '0;
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            xfer                  = in_src_rdy_i[grant_q] & ~full_i[grant_q];
            in_dst_rdy_o[grant_q] = ~full_i[grant_q];
            write_o               = xfer;
            data_out_o            = in_word[grant_q];
            block_addr_o          = grant_q;
            if (xfer) begin
               cnt_d     = cnt_inc;
               final_cnt = cnt_inc;
            end
            // An idle cycle inside a burst ends it, so a stalled source never holds the grant.
            burst_end = !xfer || in_eop_i[grant_q] || (cnt_inc == CW'(MAX_BURST));
            if (burst_end) begin
               state_d = S_IDLE;
               ptr_d   = grant_q + AW'(1);
               if (final_cnt != '0) begin
                  len_d[grant_q] = LW'(final_cnt);
                  dv_d[grant_q]  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
         dv_q    <= '0;
         for (int f = 0; f < FLOWS; f++) begin
            len_q[f] <= '0;
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         dv_q    <= dv_d;
         len_q   <= len_d;
      end
   end

endmodule

// File: tb/tb_mem2nfifo_flow_writer.sv
// Bench for mem2nfifo_flow_writer: directed scenarios plus random traffic against a transaction-level model.
module tb_mem2nfifo_flow_writer;

   localparam int DW = 64;
   localparam int F  = 8;
   localparam int BS = 512;
   localparam int MB = 16;
   localparam int AW = $clog2(F);
   localparam int LW = $clog2(BS) + 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [F*DW-1:0] in_data;
   logic [F-1:0]    src, eop, full;
   logic [F-1:0]    dst_rdy;
   logic [DW-1:0]   data_out;
   logic [AW-1:0]   block_addr;
   logic            write;
   logic [F*LW-1:0] new_len;
   logic [F-1:0]    new_len_dv;

   mem2nfifo_flow_writer #(
      .DATA_WIDTH(DW), .FLOWS(F), .BLOCK_SIZE(BS), .MAX_BURST(MB)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .in_data_i    (in_data),
      .in_src_rdy_i (src),
      .in_eop_i     (eop),
      .in_dst_rdy_o (dst_rdy),
      .data_out_o   (data_out),
      .block_addr_o (block_addr),
      .write_o      (write),
      .new_len_o    (new_len),
      .new_len_dv_o (new_len_dv),
      .full_i       (full)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Source side: words handed over per flow (advanced by the real handshake).
   int src_seq [F];
   // Reference model: words the model expects consumed, current grant, burst length, rotation start.
   int exp_seq [F];
   bit m_busy;
   int m_g, m_cnt, m_ptr, m_dv;
   int m_len [F];

   int log_f [$];
   int log_n [$];
   logic last_wr;
   logic [AW-1:0] last_addr;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input int f, input int s);
      return (DW'(f) << 48) | DW'(s);
   endfunction

   task automatic model_reset();
      m_busy = 1'b0;
      m_g    = 0;
      m_cnt  = 0;
      m_ptr  = 0;
      m_dv   = -1;
      for (int f = 0; f < F; f++) begin
         m_len[f]   = 0;
         exp_seq[f] = src_seq[f];
      end
   endtask

   // One clock cycle: inputs already driven after a negedge; check, step the model, return at next negedge.
   task automatic tick();
      logic [F-1:0]    e_dst, e_dv, acc;
      logic [F*LW-1:0] e_len;
      bit              xfer, found;
      int              nf;
      for (int f = 0; f < F; f++) in_data[f*DW +: DW] = mk(f, src_seq[f]);
      #1;
      e_dst = '0;
      xfer  = 1'b0;
      if (rst_n && m_busy) begin
         e_dst[m_g] = !full[m_g];
         xfer       = src[m_g] && !full[m_g];
      end
      e_dv = '0;
      if (rst_n && m_dv >= 0) e_dv[m_dv] = 1'b1;
      for (int f = 0; f < F; f++) e_len[f*LW +: LW] = rst_n ? LW'(m_len[f]) : '0;
      chk("write", write, xfer);
      chk("dst_rdy", dst_rdy, e_dst);
      chk("new_len_dv", new_len_dv, e_dv);
      chk("new_len", new_len, e_len);
      if (!rst_n) begin
         chk("rst_data", data_out, 0);
         chk("rst_addr", block_addr, 0);
      end
      if (xfer) begin
         chk("data", data_out, mk(m_g, exp_seq[m_g]));
         chk("addr", block_addr, m_g);
      end
      last_wr   = write;
      last_addr = block_addr;
      for (int f = 0; f < F; f++) begin
         if (new_len_dv[f]) begin
            log_f.push_back(f);
            log_n.push_back(int'(new_len[f*LW +: LW]));
         end
      end
      acc = rst_n ? (src & dst_rdy) : '0;

      if (!rst_n) begin
         model_reset();
      end else if (!m_busy) begin
         m_dv  = -1;
         found = 1'b0;
         for (int i = 0; i < F; i++) begin
            nf = (m_ptr + i) % F;
            if (!found && src[nf] && !full[nf]) begin
               found  = 1'b1;
               m_busy = 1'b1;
               m_g    = nf;
               m_cnt  = 0;
            end
         end
      end else begin
         m_dv = -1;
         if (xfer) begin
            m_cnt++;
            exp_seq[m_g]++;
         end
         if (!xfer || eop[m_g] || m_cnt == MB) begin
            m_busy = 1'b0;
            m_ptr  = (m_g + 1) % F;
            if (m_cnt > 0) begin
               m_len[m_g] = m_cnt;
               m_dv       = m_g;
            end
         end
      end

      @(negedge clk);
      for (int f = 0; f < F; f++) if (acc[f]) src_seq[f]++;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      src = '0; eop = '0; full = '0;
      tick();
      rst_n = 1'b1;
      log_f.delete();
      log_n.delete();
   endtask

   task automatic check_log(input string tag, input int ef[$], input int en[$]);
      chk({tag, "_count"}, log_f.size(), ef.size());
      for (int i = 0; i < ef.size(); i++) begin
         if (i < log_f.size()) begin
            chk({tag, "_flow"}, log_f[i], ef[i]);
            chk({tag, "_len"}, log_n[i], en[i]);
         end
      end
   endtask

   initial begin
      int ef [$];
      int en [$];
      int base, fc, n;
      rst_n = 1'b0;
      src = '0; eop = '0; full = '0; in_data = '0;
      for (int f = 0; f < F; f++) src_seq[f] = 0;
      model_reset();
      @(negedge clk);

      // Reset held with toggling inputs: everything stays quiet.
      for (int i = 0; i < 5; i++) begin
         src = F'($urandom); eop = F'($urandom); full = F'($urandom);
         tick();
      end

      // Release with flow 3 requesting: grant cycle first, then the write.
      rst_n = 1'b1; eop = '0; full = '0;
      for (int i = 0; i < 3; i++) begin
         src = 8'h08;
         tick();
         chk("first_wr", last_wr, i >= 1);
         if (i == 1) chk("first_addr", last_addr, 3);
      end

      // Single flow, 40 words.
      reset_pulse();
      base = src_seq[0];
      for (int i = 0; i < 70; i++) begin
         src = (src_seq[0] - base < 40) ? 8'h01 : 8'h00;
         tick();
      end
      ef = '{0, 0, 0}; en = '{16, 16, 8};
      check_log("single", ef, en);

      // Round robin over flows 1, 5, 7.
      reset_pulse();
      for (int i = 0; i < 103; i++) begin src = 8'hA2; tick(); end
      src = '0;
      for (int i = 0; i < 5; i++) tick();
      ef = '{1, 5, 7, 1, 5, 7}; en = '{16, 16, 16, 16, 16, 16};
      check_log("rr", ef, en);

      // EOP split after 5 words on flow 2.
      log_f.delete(); log_n.delete();
      base = src_seq[2];
      for (int i = 0; i < 12; i++) begin
         n   = src_seq[2] - base;
         src = (n < 5) ? 8'h04 : 8'h00;
         eop = (n == 4) ? 8'h04 : 8'h00;
         tick();
      end
      eop = '0;
      ef = '{2}; en = '{5};
      check_log("eop", ef, en);

      // FULL on flow 4 after 3 words, held 5 cycles.
      log_f.delete(); log_n.delete();
      base = src_seq[4]; fc = 0;
      for (int i = 0; i < 30; i++) begin
         n    = src_seq[4] - base;
         src  = (n < 10) ? 8'h10 : 8'h00;
         full = (n >= 3 && fc < 5) ? 8'h10 : 8'h00;
         if (full[4]) fc++;
         tick();
      end
      full = '0;
      ef = '{4, 4}; en = '{3, 7};
      check_log("full", ef, en);

      // Reset 7 words into a flow 6 burst: those words are never committed.
      log_f.delete(); log_n.delete();
      base = src_seq[6];
      for (int i = 0; i < 40 && (src_seq[6] - base) < 7; i++) begin
         src = 8'h40;
         tick();
      end
      chk("rst_mid_reach", src_seq[6] - base, 7);
      rst_n = 1'b0; src = 8'h44;
      tick(); tick();
      chk("rst_no_commit", log_f.size(), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      ef = '{2}; en = '{16};
      check_log("rst_restart", ef, en);
      src = '0;
      for (int i = 0; i < 3; i++) tick();

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 499) != 0);
         src   = F'($urandom | $urandom);
         eop   = F'($urandom & $urandom & $urandom);
         full  = F'($urandom & $urandom & $urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
